// File: rtl/branch_pkg.sv
// Shared constants and types for the fetch redirect controller.
// Holds the CTI opcode field values and the redirect FSM state type.
package branch_pkg;

   localparam logic [4:0] BRANCH = 5'b11000;
   localparam logic [4:0] JAL    = 5'b11011;
   localparam logic [4:0] JALR   = 5'b11001;

   typedef enum logic [1:0] {
      IDLE,
      REDIRECT,
      SQUASH
   } redir_state_t;

   // True when opcode[6:2] names a control-transfer instruction.
   function automatic logic is_cti_op(input logic [4:0] op);
      return (op == BRANCH) || (op == JAL) || (op == JALR);
   endfunction

endpackage

// File: rtl/br_stat_cnt.sv
// Free-running wrap-around event counter with synchronous active-high clear.
module br_stat_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch redirect sequencer: flushes and steers the PC mux on a taken CTI, then squashes
// wrong-path fetch responses. Optional statistics counters are built when BR_STATS_EN is defined.
module branch_redirect_ctrl
   import branch_pkg::*;
#(
   parameter int unsigned W         = 32,
   parameter int unsigned FETCH_LAT = 1
`ifdef BR_STATS_EN
   ,
   parameter int unsigned CNT_W     = 32
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             ex_is_cti,
   input  logic             ex_jump,
   input  logic [W-1:0]     ex_target,
   input  logic             stall,
   input  logic             imem_ready,
   output logic             pc_sel,
   output logic [W-1:0]     redirect_pc,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             squash_fetch,
   output logic             busy,
   output logic             misalign
`ifdef BR_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_cti,
   output logic [CNT_W-1:0] stat_taken
`endif
);

   localparam logic [2:0] SqInit = 3'(FETCH_LAT);

   redir_state_t state_q, state_d;
   logic [W-1:0] tgt_q, tgt_d;
   logic [2:0]   sq_cnt_q, sq_cnt_d;
   logic [W-1:0] new_tgt;
   logic         take;
   logic         unused_tgt0;

   // branch_control raises ex_jump for non-CTIs too, so ex_is_cti must qualify it.
   assign take        = ex_valid & ex_is_cti & ex_jump & ~stall & (state_q == IDLE);
   assign new_tgt     = {ex_target[W-1:1], 1'b0};
   assign unused_tgt0 = ex_target[0];

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      sq_cnt_d     = sq_cnt_q;
      pc_sel       = 1'b0;
      redirect_pc  = tgt_q;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      squash_fetch = 1'b0;
      misalign     = take & ex_target[1];

      unique case (state_q)
         IDLE: begin
            if (take) begin
               pc_sel      = 1'b1;
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               redirect_pc = new_tgt;
               tgt_d       = new_tgt;
               if (!imem_ready) begin
                  state_d = REDIRECT;
               end else if (FETCH_LAT != 0) begin
                  state_d  = SQUASH;
                  sq_cnt_d = SqInit;
               end
            end
         end
         REDIRECT: begin
            pc_sel = 1'b1;
            if (imem_ready) begin
               if (FETCH_LAT != 0) begin
                  state_d  = SQUASH;
                  sq_cnt_d = SqInit;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         SQUASH: begin
            squash_fetch = 1'b1;
            sq_cnt_d     = sq_cnt_q - 3'd1;
            if (sq_cnt_q == 3'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tgt_q    <= '0;
         sq_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         sq_cnt_q <= sq_cnt_d;
      end
   end

   assign busy = (state_q != IDLE);

   // The hazard unit holds ID while busy, so EX must never present work here.
   illegal_ex_valid: assert property (@(posedge clk) disable iff (rst)
      !(ex_valid && (state_q != IDLE)));

`ifdef BR_STATS_EN
   br_stat_cnt #(
      .CNT_W(CNT_W)
   ) u_stat_cti (
      .clk  (clk),
      .rst  (rst),
      .inc  (ex_valid & ex_is_cti & ~stall),
      .count(stat_cti)
   );

   br_stat_cnt #(
      .CNT_W(CNT_W)
   ) u_stat_taken (
      .clk  (clk),
      .rst  (rst),
      .inc  (take),
      .count(stat_taken)
   );
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed scoreboard bench for branch_redirect_ctrl (W=32, FETCH_LAT=1).
// Statistics checks are built when BR_STATS_EN is defined.
module tb_branch_redirect_ctrl;
   import branch_pkg::*;

   localparam logic [4:0] OpAlu = 5'b01100;

   typedef struct packed {
      logic        pc_sel;
      logic [31:0] rpc;
      logic        fl_if;
      logic        fl_ex;
      logic        sq;
      logic        busy;
      logic        mis;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_is_cti, ex_jump, stall, imem_ready;
   logic [31:0] ex_target;
   logic        pc_sel, flush_if_id, flush_id_ex, squash_fetch, busy, misalign;
   logic [31:0] redirect_pc;
`ifdef BR_STATS_EN
   logic [1:0]  stat_cti, stat_taken;
`endif

   obs_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(
      .W        (32),
      .FETCH_LAT(1)
`ifdef BR_STATS_EN
      ,
      .CNT_W    (2)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_is_cti   (ex_is_cti),
      .ex_jump     (ex_jump),
      .ex_target   (ex_target),
      .stall       (stall),
      .imem_ready  (imem_ready),
      .pc_sel      (pc_sel),
      .redirect_pc (redirect_pc),
      .flush_if_id (flush_if_id),
      .flush_id_ex (flush_id_ex),
      .squash_fetch(squash_fetch),
      .busy        (busy),
      .misalign    (misalign)
`ifdef BR_STATS_EN
      ,
      .stat_cti    (stat_cti),
      .stat_taken  (stat_taken)
`endif
   );

   function automatic obs_t ex(input logic p, input logic [31:0] r, input logic f,
                               input logic s, input logic b, input logic m);
      return '{pc_sel: p, rpc: r, fl_if: f, fl_ex: f, sq: s, busy: b, mis: m};
   endfunction

   // Drive one cycle of EX/imem inputs, queue the expected outputs, compare mid-cycle.
   task automatic step(input string tag, input logic v, input logic [4:0] op, input logic j,
                       input logic [31:0] t, input logic s, input logic r, input obs_t e);
      obs_t got, want;
      ex_valid   = v;
      ex_is_cti  = is_cti_op(op);
      ex_jump    = j;
      ex_target  = t;
      stall      = s;
      imem_ready = r;
      sb.push_back(e);
      @(negedge clk);
      got  = '{pc_sel: pc_sel, rpc: redirect_pc, fl_if: flush_if_id, fl_ex: flush_id_ex,
               sq: squash_fetch, busy: busy, mis: misalign};
      want = sb.pop_front();
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed pc_sel=%b rpc=%h fl=%b/%b sq=%b busy=%b mis=%b expected pc_sel=%b rpc=%h fl=%b/%b sq=%b busy=%b mis=%b",
                tag, got.pc_sel, got.rpc, got.fl_if, got.fl_ex, got.sq, got.busy, got.mis,
                want.pc_sel, want.rpc, want.fl_if, want.fl_ex, want.sq, want.busy, want.mis);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string tag, input logic r, input obs_t e);
      step(tag, 1'b0, OpAlu, 1'b0, 32'h0, 1'b0, r, e);
   endtask

   initial begin
      rst = 1'b1;
      ex_valid = 1'b0; ex_is_cti = 1'b0; ex_jump = 1'b0; ex_target = '0;
      stall = 1'b0; imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      idle("reset", 1'b1, ex(0, 32'h0, 0, 0, 0, 0));

      // BEQ taken, imem accepts immediately, one squash cycle
      step("beq_take", 1, BRANCH, 1, 32'h100, 0, 1, ex(1, 32'h100, 1, 0, 0, 0));
      idle("beq_squash", 1'b1, ex(0, 32'h100, 0, 1, 1, 0));
      idle("beq_idle", 1'b1, ex(0, 32'h100, 0, 0, 0, 0));

      // JAL with odd target, imem stalls for three cycles
      step("jal_take", 1, JAL, 1, 32'h2001, 0, 0, ex(1, 32'h2000, 1, 0, 0, 0));
      idle("jal_wait1", 1'b0, ex(1, 32'h2000, 0, 0, 1, 0));
      idle("jal_wait2", 1'b0, ex(1, 32'h2000, 0, 0, 1, 0));
      idle("jal_accept", 1'b1, ex(1, 32'h2000, 0, 0, 1, 0));
      idle("jal_squash", 1'b1, ex(0, 32'h2000, 0, 1, 1, 0));
      idle("jal_idle", 1'b1, ex(0, 32'h2000, 0, 0, 0, 0));

      // Jump flag on a non-CTI and a not-taken branch are both ignored
      step("add_jump", 1, OpAlu, 1, 32'h500, 0, 1, ex(0, 32'h2000, 0, 0, 0, 0));
      idle("add_after", 1'b1, ex(0, 32'h2000, 0, 0, 0, 0));
      step("bne_not_taken", 1, BRANCH, 0, 32'h600, 0, 1, ex(0, 32'h2000, 0, 0, 0, 0));

      // Taken BNE held by stall for two cycles
      step("bne_stall1", 1, BRANCH, 1, 32'h40, 1, 1, ex(0, 32'h2000, 0, 0, 0, 0));
      step("bne_stall2", 1, BRANCH, 1, 32'h40, 1, 1, ex(0, 32'h2000, 0, 0, 0, 0));
      step("bne_go", 1, BRANCH, 1, 32'h40, 0, 1, ex(1, 32'h40, 1, 0, 0, 0));
      idle("bne_squash", 1'b1, ex(0, 32'h40, 0, 1, 1, 0));

      // Misaligned taken target still redirects
      step("mis_take", 1, JALR, 1, 32'h302, 0, 1, ex(1, 32'h302, 1, 0, 0, 1));
      idle("mis_squash", 1'b1, ex(0, 32'h302, 0, 1, 1, 0));
      idle("mis_idle", 1'b1, ex(0, 32'h302, 0, 0, 0, 0));

      // Reset while in REDIRECT drops the pending redirect
      step("rst_take", 1, BRANCH, 1, 32'h880, 0, 0, ex(1, 32'h880, 1, 0, 0, 0));
      idle("rst_redirect", 1'b0, ex(1, 32'h880, 0, 0, 1, 0));
      rst = 1'b1;
      idle("rst_cycle", 1'b0, ex(1, 32'h880, 0, 0, 1, 0));
      rst = 1'b0;
      idle("rst_after", 1'b0, ex(0, 32'h0, 0, 0, 0, 0));

`ifdef BR_STATS_EN
      // Five counted CTIs (three taken) on 2-bit counters
      step("st_beq", 1, BRANCH, 1, 32'h10, 0, 1, ex(1, 32'h10, 1, 0, 0, 0));
      idle("st_beq_sq", 1'b1, ex(0, 32'h10, 0, 1, 1, 0));
      step("st_bne_nt", 1, BRANCH, 0, 32'h20, 0, 1, ex(0, 32'h10, 0, 0, 0, 0));
      step("st_jal", 1, JAL, 1, 32'h30, 0, 1, ex(1, 32'h30, 1, 0, 0, 0));
      idle("st_jal_sq", 1'b1, ex(0, 32'h30, 0, 1, 1, 0));
      step("st_stalled", 1, BRANCH, 1, 32'h50, 1, 1, ex(0, 32'h30, 0, 0, 0, 0));
      step("st_jalr_nt", 1, JALR, 0, 32'h60, 0, 1, ex(0, 32'h30, 0, 0, 0, 0));
      step("st_jalr", 1, JALR, 1, 32'h70, 0, 1, ex(1, 32'h70, 1, 0, 0, 0));
      idle("st_jalr_sq", 1'b1, ex(0, 32'h70, 0, 1, 1, 0));
      @(negedge clk);
      checks++;
      assert (stat_cti === 2'(5 % 4)) else begin
         errors++;
         $error("FAIL stat_cti: observed %0d expected %0d", stat_cti, 5 % 4);
      end
      checks++;
      assert (stat_taken === 2'd3) else begin
         errors++;
         $error("FAIL stat_taken: observed %0d expected 3", stat_taken);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
